// File: rtl/score_pkg.sv
// Shared types and helpers for the scoreboard controller: FSM states, default
// score limit and the timer-width function.
package score_pkg;

    typedef enum logic [2:0] {
        IDLE,
        UP_HI,
        DN_HI,
        CLR,
        GAP
    } state_t;

    localparam int MAX_VAL_DEF = 99;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/score_ctrl_btn_debounce.sv
// One push-button input path: 2-FF synchronizer, stability-count debouncer and
// a one-cycle pulse on each rising edge of the debounced level.
module btn_debounce
    import score_pkg::*;
#(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    localparam int CW = clog2(DEB_CYCLES + 1);

    logic          sync_p0;
    logic          sync_p1;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    // Synchronizer stages
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= btn;
            sync_p1 <= sync_p0;
        end
    end

    // Debounce: the level only follows after DEB_CYCLES consecutive mismatches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
        end else begin
            level_d <= level;
            if (sync_p1 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                level <= sync_p1;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign rise = level & ~level_d;

endmodule

// File: rtl/score_ctrl.sv
// Scoreboard counter sequencer: debounced buttons set pending requests, and a
// small FSM turns them into spaced, limit-checked up/down/reset strobes.
module score_ctrl
    import score_pkg::*;
#(
    parameter int BW           = 7,
    parameter int MAX_VAL      = MAX_VAL_DEF,
    parameter int DEB_CYCLES   = 4,
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          btn_up_i,
    input  logic          btn_down_i,
    input  logic          btn_clr_i,
    output logic          cnt_up_o,
    output logic          cnt_down_o,
    output logic          cnt_rst_o,
    output logic          busy_o,
    output logic          sat_o,
    output logic [BW-1:0] score_o
);

    localparam int TMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int TW   = clog2(TMAX + 1);

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nxt;
    logic [BW-1:0] score;
    logic [BW-1:0] score_nxt;
    logic          rise_up;
    logic          rise_dn;
    logic          rise_clr;
    logic          pend_up;
    logic          pend_dn;
    logic          pend_clr;
    logic          take_up;
    logic          take_dn;
    logic          take_all;
    logic          sat_nxt;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
        .clk  (clk_i),
        .rst  (rst_i),
        .btn  (btn_up_i),
        .rise (rise_up)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
        .clk  (clk_i),
        .rst  (rst_i),
        .btn  (btn_down_i),
        .rise (rise_dn)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
        .clk  (clk_i),
        .rst  (rst_i),
        .btn  (btn_clr_i),
        .rise (rise_clr)
    );

    // Pending flags: a new edge wins over a same-cycle consume
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_up  <= 1'b0;
            pend_dn  <= 1'b0;
            pend_clr <= 1'b0;
        end else begin
            pend_up  <= (pend_up  & ~(take_up | take_all)) | rise_up;
            pend_dn  <= (pend_dn  & ~(take_dn | take_all)) | rise_dn;
            pend_clr <= (pend_clr & ~take_all)             | rise_clr;
        end
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        score_nxt = score;
        take_up   = 1'b0;
        take_dn   = 1'b0;
        take_all  = 1'b0;
        sat_nxt   = 1'b0;
        case (state)
            IDLE: begin
                timer_nxt = '0;
                if (pend_clr) begin
                    state_nxt = CLR;
                    score_nxt = '0;
                    take_all  = 1'b1;
                end else if (pend_up && pend_dn) begin
                    take_up = 1'b1;
                    take_dn = 1'b1;
                end else if (pend_up) begin
                    take_up = 1'b1;
                    if (score < BW'(MAX_VAL)) begin
                        state_nxt = UP_HI;
                        score_nxt = score + 1'b1;
                    end else begin
                        sat_nxt = 1'b1;
                    end
                end else if (pend_dn) begin
                    take_dn = 1'b1;
                    if (score != '0) begin
                        state_nxt = DN_HI;
                        score_nxt = score - 1'b1;
                    end else begin
                        sat_nxt = 1'b1;
                    end
                end
            end
            UP_HI, DN_HI, CLR: begin
                if (timer == TW'(PULSE_CYCLES - 1)) begin
                    state_nxt = GAP;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            GAP: begin
                if (timer == TW'(GAP_CYCLES - 1)) begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                timer_nxt = '0;
            end
        endcase
    end

    // Strobes are decoded from the next state so they are glitch-free flops
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            timer      <= '0;
            score      <= '0;
            cnt_up_o   <= 1'b0;
            cnt_down_o <= 1'b0;
            busy_o     <= 1'b0;
            sat_o      <= 1'b0;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            score      <= score_nxt;
            cnt_up_o   <= (state_nxt == UP_HI);
            cnt_down_o <= (state_nxt == DN_HI);
            busy_o     <= (state_nxt != IDLE);
            sat_o      <= sat_nxt;
        end
    end

    assign cnt_rst_o = rst_i | (state == CLR);
    assign score_o   = score;

endmodule

// File: tb/tb_score_ctrl.sv
// Directed bench for score_ctrl with hand-derived timing and a strobe-shape monitor.
module tb_score_ctrl;

    logic       clk;
    logic       rst;
    logic       btn_up;
    logic       btn_down;
    logic       btn_clr;
    logic       cnt_up;
    logic       cnt_down;
    logic       cnt_rst;
    logic       busy;
    logic       sat;
    logic [6:0] score;

    int errors;
    int checks;
    int up_rises, dn_rises, rs_rises, sat_rises;
    int up_len, dn_len, rs_len, sat_len, low_run;
    logic prev_up, prev_dn, prev_rs, prev_sat, seen_strobe;
    int up_base, dn_base, rs_base, sat_base;

    score_ctrl dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .btn_up_i   (btn_up),
        .btn_down_i (btn_down),
        .btn_clr_i  (btn_clr),
        .cnt_up_o   (cnt_up),
        .cnt_down_o (cnt_down),
        .cnt_rst_o  (cnt_rst),
        .busy_o     (busy),
        .sat_o      (sat),
        .score_o    (score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // kind: 0 up, 1 down, 2 clear, 3 up+down, 4 clear+up
    task automatic press(input int kind);
        btn_up   = (kind == 0 || kind == 3 || kind == 4);
        btn_down = (kind == 1 || kind == 3);
        btn_clr  = (kind == 2 || kind == 4);
        tick(10);
        btn_up = 1'b0; btn_down = 1'b0; btn_clr = 1'b0;
        tick(14);
    endtask

    task automatic snap();
        up_base = up_rises; dn_base = dn_rises; rs_base = rs_rises; sat_base = sat_rises;
    endtask

    // Strobe shape monitor: widths, exclusivity and low time between strobes
    always @(negedge clk) begin
        if (rst) begin
            up_len = 0; dn_len = 0; rs_len = 0; sat_len = 0; low_run = 100;
            prev_up = 0; prev_dn = 0; prev_rs = 0; prev_sat = 0; seen_strobe = 0;
        end else begin
            check("mutex", int'(cnt_up) + int'(cnt_down) + int'(cnt_rst) <= 1, 1);
            if ((cnt_up | cnt_down | cnt_rst) && !(prev_up | prev_dn | prev_rs)) begin
                if (seen_strobe) check("gap_low", low_run >= 2, 1);
                seen_strobe = 1;
            end
            low_run = (cnt_up | cnt_down | cnt_rst) ? 0 : low_run + 1;
            if (cnt_up && !prev_up) up_rises++;
            if (cnt_down && !prev_dn) dn_rises++;
            if (cnt_rst && !prev_rs) rs_rises++;
            if (sat && !prev_sat) sat_rises++;
            if (cnt_up) up_len++;
            else if (prev_up) begin check("up_len", up_len, 2); up_len = 0; end
            if (cnt_down) dn_len++;
            else if (prev_dn) begin check("dn_len", dn_len, 2); dn_len = 0; end
            if (cnt_rst) rs_len++;
            else if (prev_rs) begin check("rst_len", rs_len, 2); rs_len = 0; end
            if (sat) sat_len++;
            else if (prev_sat) begin check("sat_len", sat_len, 1); sat_len = 0; end
            prev_up = cnt_up; prev_dn = cnt_down; prev_rs = cnt_rst; prev_sat = sat;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        errors = 0; checks = 0;
        up_rises = 0; dn_rises = 0; rs_rises = 0; sat_rises = 0;
        rst = 1'b1; btn_up = 1'b0; btn_down = 1'b0; btn_clr = 1'b0;
        tick(3);
        check("rst_up", cnt_up, 0);
        check("rst_down", cnt_down, 0);
        check("rst_cntrst", cnt_rst, 1);
        check("rst_busy", busy, 0);
        check("rst_sat", sat, 0);
        check("rst_score", score, 0);
        rst = 1'b0;
        #1;
        check("rel_cntrst", cnt_rst, 0);
        tick(3);

        // Clean up press: strobe at edge 8, two cycles, busy four cycles
        btn_up = 1'b1;
        tick(7);
        check("lat_up7", cnt_up, 0);
        check("lat_score7", score, 0);
        tick(1);
        check("lat_up8", cnt_up, 1);
        check("lat_score8", score, 1);
        check("lat_busy8", busy, 1);
        tick(1);
        check("lat_up9", cnt_up, 1);
        tick(1);
        btn_up = 1'b0;
        check("lat_up10", cnt_up, 0);
        check("lat_busy10", busy, 1);
        tick(1);
        check("lat_busy11", busy, 1);
        tick(1);
        check("lat_busy12", busy, 0);
        tick(12);

        // Bring score back to 0
        press(1);
        check("down_to0", score, 0);

        // Short glitches never get through the debouncer
        snap();
        for (int i = 0; i < 5; i++) begin
            btn_down = 1'b1; tick(3);
            btn_down = 1'b0; tick(1);
        end
        tick(16);
        check("glitch_dn", dn_rises - dn_base, 0);
        check("glitch_score", score, 0);

        // Down at zero: one sat pulse at edge 8, no strobe
        btn_down = 1'b1;
        tick(7);
        check("sat0_7", sat, 0);
        tick(1);
        check("sat0_8", sat, 1);
        tick(1);
        check("sat0_9", sat, 0);
        tick(1);
        btn_down = 1'b0;
        tick(14);
        check("sat0_dn", dn_rises - dn_base, 0);
        check("sat0_score", score, 0);

        // Fill to the upper limit
        snap();
        for (int i = 0; i < 99; i++) press(0);
        check("fill_ups", up_rises - up_base, 99);
        check("fill_score", score, 99);
        snap();
        press(0);
        check("max_up", up_rises - up_base, 0);
        check("max_sat", sat_rises - sat_base, 1);
        check("max_score", score, 99);
        press(1);
        check("max_dn", dn_rises - dn_base, 1);
        check("max_dn_score", score, 98);

        // Simultaneous up and down cancel each other
        snap();
        press(3);
        check("both_up", up_rises - up_base, 0);
        check("both_dn", dn_rises - dn_base, 0);
        check("both_sat", sat_rises - sat_base, 0);
        check("both_score", score, 98);

        // Down arriving while up is busy waits for the next IDLE
        btn_up = 1'b1;
        tick(2);
        btn_down = 1'b1;
        tick(6);
        check("q_up8", cnt_up, 1);
        check("q_score8", score, 99);
        tick(4);
        check("q_dn12", cnt_down, 0);
        tick(1);
        check("q_dn13", cnt_down, 1);
        check("q_score13", score, 98);
        btn_up = 1'b0; btn_down = 1'b0;
        tick(16);

        // Two up presses back to back from 97
        press(1);
        snap();
        btn_up = 1'b1; tick(6);
        btn_up = 1'b0; tick(6);
        btn_up = 1'b1; tick(10);
        btn_up = 1'b0; tick(14);
        check("two_ups", up_rises - up_base, 2);
        check("two_score", score, 99);

        // Clear, then count to 37 and clear again
        snap();
        press(2);
        check("clr_score", score, 0);
        check("clr_rst", rs_rises - rs_base, 1);
        for (int i = 0; i < 37; i++) press(0);
        check("c37_score", score, 37);
        snap();
        press(2);
        check("c37_clr", score, 0);
        check("c37_rst", rs_rises - rs_base, 1);
        press(0);
        check("pre_cu", score, 1);
        snap();
        press(4);
        check("cu_rst", rs_rises - rs_base, 1);
        check("cu_up", up_rises - up_base, 0);
        check("cu_score", score, 0);

        // Asynchronous reset in the middle of an up strobe
        btn_up = 1'b1;
        tick(8);
        check("ar_up", cnt_up, 1);
        rst = 1'b1;
        #1;
        check("ar_up_off", cnt_up, 0);
        check("ar_cntrst", cnt_rst, 1);
        check("ar_busy", busy, 0);
        check("ar_score", score, 0);
        btn_up = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);
        snap();
        tick(20);
        check("ar_after_up", up_rises - up_base, 0);
        check("ar_after_score", score, 0);
        check("ar_after_busy", busy, 0);
        check("ar_after_rst", cnt_rst, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
